// File: rtl/dresp_pkg.sv
// dresp_pkg: shared widths, default base address and the response entry
// carried through the latency pipe and the response FIFO.
package dresp_pkg;
    localparam int TAG_W  = 11;
    localparam int DATA_W = 32;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h8000_0000;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              error;
        logic [TAG_W-1:0]  tag;
    } resp_t;
endpackage

// File: rtl/dresp_if.sv
// dresp_if: data-side memory request/response bus.
//   master : drives address, write data, rd/wr strobes, maintenance flags, tag;
//            receives accept, ack, read data, error and response tag.
//   slave  : the opposite directions (used by dresp_model).
interface dresp_if;
    import dresp_pkg::*;

    logic [31:0]       mem_d_addr_i;
    logic [DATA_W-1:0] mem_d_data_wr_i;
    logic              mem_d_rd_i;
    logic [3:0]        mem_d_wr_i;
    logic              mem_d_cacheable_i;
    logic [TAG_W-1:0]  mem_d_req_tag_i;
    logic              mem_d_invalidate_i;
    logic              mem_d_writeback_i;
    logic              mem_d_flush_i;
    logic              mem_d_accept_o;
    logic              mem_d_ack_o;
    logic [DATA_W-1:0] mem_d_data_rd_o;
    logic              mem_d_error_o;
    logic [TAG_W-1:0]  mem_d_resp_tag_o;

    modport master (
        output mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        input  mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
               mem_d_resp_tag_o
    );

    modport slave (
        input  mem_d_addr_i, mem_d_data_wr_i, mem_d_rd_i, mem_d_wr_i,
               mem_d_cacheable_i, mem_d_req_tag_i, mem_d_invalidate_i,
               mem_d_writeback_i, mem_d_flush_i,
        output mem_d_accept_o, mem_d_ack_o, mem_d_data_rd_o, mem_d_error_o,
               mem_d_resp_tag_o
    );
endinterface

// File: rtl/dresp_fifo.sv
// dresp_fifo: response FIFO with fall-through when empty.
//   clk_i, rst_i    : clock, async active-low reset (empties the FIFO)
//   push_i/push_data_i : entry leaving the latency pipe
//   pop_i           : consume the presented head this cycle
//   valid_o/head_o  : head entry (the incoming push when the FIFO is empty)
// The fall-through lets an entry be popped on the very edge it arrives,
// which keeps the accept-to-ack latency exactly equal to the pipe length.
module dresp_fifo #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = dresp_pkg::resp_t
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   push_i,
    input  entry_t push_data_i,
    input  logic   pop_i,
    output logic   valid_o,
    output entry_t head_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW:0]     fill_q;
    logic            empty, store, adv;

    assign empty   = (fill_q == '0);
    assign valid_o = !empty || push_i;
    assign head_o  = empty ? push_data_i : mem_q[rptr_q];
    // A push bypassed straight to the output is never stored.
    assign store   = push_i && !(empty && pop_i);
    assign adv     = pop_i && !empty;

    always_ff @(posedge clk_i) begin
        if (store) mem_q[wptr_q] <= push_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
        end else begin
            if (store) wptr_q <= wptr_q + 1'b1;
            if (adv)   rptr_q <= rptr_q + 1'b1;
            case ({store, adv})
                2'b10:   fill_q <= fill_q + 1'b1;
                2'b01:   fill_q <= fill_q - 1'b1;
                default: fill_q <= fill_q;
            endcase
        end
    end
endmodule

// File: rtl/dresp_model.sv
// dresp_model: behavioural data-memory responder with fixed latency,
// in-order responses and bounded outstanding requests.
//   clk_i        : clock
//   rst_i        : async active-low reset (array contents survive it)
//   resp_stall_i : holds responses in the FIFO while high
//   bus          : dresp_if.slave request/response bus
// Optional feature: define DRESP_RANGE_ERR_EN to flag requests outside
// [BASE_ADDR, BASE_ADDR + 4*2^ADDR_W) with error=1, data 0 and no write.
module dresp_model import dresp_pkg::*; #(
    parameter int          ADDR_W    = 8,
    parameter int          LATENCY   = 2,
    parameter int          DEPTH     = 4,
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    resp_stall_i,
    dresp_if.slave  bus
);
    localparam int WORDS = 1 << ADDR_W;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [ADDR_W-1:0] idx;
    logic              is_req, is_wr, acc, in_range, do_wr;
    logic              pop, fifo_valid;
    logic [CW-1:0]     cnt_q;
    logic [LATENCY-1:0] pipe_v;
    resp_t             pipe_e [LATENCY];
    resp_t             new_e, head, resp_q;
    logic              ack_q;
    logic              unused_bits;

    assign idx    = bus.mem_d_addr_i[ADDR_W+1:2];
    assign is_wr  = |bus.mem_d_wr_i;
    assign is_req = bus.mem_d_rd_i | is_wr | bus.mem_d_invalidate_i
                  | bus.mem_d_writeback_i | bus.mem_d_flush_i;
    assign bus.mem_d_accept_o = (cnt_q < CW'(DEPTH));
    assign acc    = is_req && bus.mem_d_accept_o;
    assign unused_bits = ^{bus.mem_d_cacheable_i, bus.mem_d_addr_i[1:0],
                           bus.mem_d_addr_i[31:ADDR_W+2]};

`ifdef DRESP_RANGE_ERR_EN
    logic [31:0] offset;
    assign offset   = bus.mem_d_addr_i - BASE_ADDR;
    assign in_range = ((offset >> (ADDR_W + 2)) == 32'd0);
`else
    assign in_range = 1'b1;
`endif

    assign do_wr = acc && is_wr && in_range;

    // Read data is taken from the pre-write array value; a rd+wr request
    // is a write and answers with data 0.
    always_comb begin
        new_e       = '0;
        new_e.error = !in_range;
        new_e.tag   = bus.mem_d_req_tag_i;
        if (in_range && bus.mem_d_rd_i && !is_wr) new_e.data = mem_q[idx];
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.mem_d_wr_i[b])
                    mem_q[idx][8*b +: 8] <= bus.mem_d_data_wr_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pipe_v <= '0;
        end else begin
            pipe_v[0] <= acc;
            for (int i = 1; i < LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        pipe_e[0] <= new_e;
        for (int i = 1; i < LATENCY; i++) pipe_e[i] <= pipe_e[i-1];
    end

    dresp_fifo #(.DEPTH(DEPTH), .entry_t(resp_t)) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (pipe_v[LATENCY-1]),
        .push_data_i (pipe_e[LATENCY-1]),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .head_o      (head)
    );

    assign pop = fifo_valid && !resp_stall_i;

    // The count covers pipe and FIFO together, so the FIFO can never hold
    // more than DEPTH entries.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            resp_q <= '0;
        end else begin
            case ({acc, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            ack_q <= pop;
            if (pop) resp_q <= head;
        end
    end

    assign bus.mem_d_ack_o      = ack_q;
    assign bus.mem_d_data_rd_o  = resp_q.data;
    assign bus.mem_d_error_o    = resp_q.error;
    assign bus.mem_d_resp_tag_o = resp_q.tag;
endmodule

// File: tb/tb_dresp_model.sv
// tb_dresp_model: scoreboard bench for dresp_model. Requests push their
// hand-computed response onto a queue; a negedge monitor pops and compares
// on every ack.
module tb_dresp_model;
    localparam int LAT = 2;
`ifdef DRESP_RANGE_ERR_EN
    localparam bit RERR = 1'b1;
`else
    localparam bit RERR = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [10:0] tag;
        int          cyc;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    logic resp_stall_i = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   ack_log[$];

    dresp_if bus();

    dresp_model #(.ADDR_W(8), .LATENCY(LAT), .DEPTH(4), .BASE_ADDR(32'h8000_0000)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .resp_stall_i (resp_stall_i),
        .bus          (bus)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_i && bus.mem_d_ack_o) begin
            exp_t e;
            ack_log.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got tag %h expected no ack (cycle %0d)",
                         bus.mem_d_resp_tag_o, cyc);
            end else begin
                e = exp_q.pop_front();
                check("ack_tag", 32'(bus.mem_d_resp_tag_o), 32'(e.tag));
                check("ack_data", bus.mem_d_data_rd_o, e.data);
                check("ack_error", 32'(bus.mem_d_error_o), 32'(e.err));
                if (e.cyc >= 0) check("ack_latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic clear_req();
        bus.mem_d_addr_i       = '0;
        bus.mem_d_data_wr_i    = '0;
        bus.mem_d_rd_i         = 1'b0;
        bus.mem_d_wr_i         = 4'h0;
        bus.mem_d_cacheable_i  = 1'b0;
        bus.mem_d_req_tag_i    = '0;
        bus.mem_d_invalidate_i = 1'b0;
        bus.mem_d_writeback_i  = 1'b0;
        bus.mem_d_flush_i      = 1'b0;
    endtask

    // mnt = {flush, writeback, invalidate}
    task automatic issue(input logic rd, input logic [3:0] wr, input logic [2:0] mnt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [10:0] tag, input logic [31:0] ed,
                         input logic ee, input bit lat);
        int   waited = 0;
        exp_t e;
        @(negedge clk_i);
        bus.mem_d_addr_i       = addr;
        bus.mem_d_data_wr_i    = wdata;
        bus.mem_d_rd_i         = rd;
        bus.mem_d_wr_i         = wr;
        bus.mem_d_cacheable_i  = 1'b1;
        bus.mem_d_req_tag_i    = tag;
        bus.mem_d_invalidate_i = mnt[0];
        bus.mem_d_writeback_i  = mnt[1];
        bus.mem_d_flush_i      = mnt[2];
        while (!bus.mem_d_accept_o && waited < 200) begin
            @(negedge clk_i);
            waited++;
        end
        if (!bus.mem_d_accept_o) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got accept 0 expected 1 for tag %h", tag);
        end else begin
            e.data = ed;
            e.err  = ee;
            e.tag  = tag;
            e.cyc  = lat ? cyc + 1 + LAT : -1;
            exp_q.push_back(e);
            @(posedge clk_i);
        end
        #1 clear_req();
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(negedge clk_i);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    int base;
    int rel_cyc;

    initial begin
        clear_req();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_ack", 32'(bus.mem_d_ack_o), 32'd0);
        check("rst_data", bus.mem_d_data_rd_o, 32'd0);
        check("rst_error", 32'(bus.mem_d_error_o), 32'd0);
        check("rst_tag", 32'(bus.mem_d_resp_tag_o), 32'd0);
        check("rst_accept", 32'(bus.mem_d_accept_o), 32'd1);

        // write then read back, exact latency
        issue(0, 4'hF, 3'b000, 32'h8000_0004, 32'hDEAD_BEEF, 11'd3, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'd4, 32'hDEAD_BEEF, 1'b0, 1);
        drain();

        // byte strobes and rd+wr treated as write
        issue(0, 4'hF, 3'b000, 32'h8000_0008, 32'h1122_3344, 11'd5, 32'h0, 1'b0, 1);
        issue(0, 4'b0001, 3'b000, 32'h8000_0008, 32'h0000_00AA, 11'd6, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_0008, 32'h0, 11'd7, 32'h1122_33AA, 1'b0, 1);
        issue(1, 4'b0010, 3'b000, 32'h8000_0008, 32'h0000_BB00, 11'd8, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_0008, 32'h0, 11'd9, 32'h1122_BBAA, 1'b0, 1);
        drain();

        // maintenance: flush + invalidate, one ack, nothing modified
        issue(0, 4'h0, 3'b101, 32'h8000_0008, 32'hFFFF_FFFF, 11'h055, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_0008, 32'h0, 11'h056, 32'h1122_BBAA, 1'b0, 1);
        drain();

        // last word, and one-past-end wrap / range error
        issue(0, 4'hF, 3'b000, 32'h8000_03FC, 32'h5A5A_5A5A, 11'h10, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_03FC, 32'h0, 11'h11, 32'h5A5A_5A5A, 1'b0, 1);
        issue(0, 4'hF, 3'b000, 32'h8000_0000, 32'h0101_0101, 11'h12, 32'h0, 1'b0, 1);
        issue(0, 4'hF, 3'b000, 32'h8000_0400, 32'hCAFE_0001, 11'h13, 32'h0, RERR, 1);
        issue(1, 4'h0, 3'b000, 32'h8000_0000, 32'h0, 11'h14,
              RERR ? 32'h0101_0101 : 32'hCAFE_0001, 1'b0, 1);
        issue(0, 4'hF, 3'b000, 32'h8000_0010, 32'h4444_4444, 11'h15, 32'h0, 1'b0, 1);
        issue(1, 4'h0, 3'b000, 32'h0000_0010, 32'h0, 11'h16,
              RERR ? 32'h0 : 32'h4444_4444, RERR, 1);
        drain();

        // full-rate reads, each exactly LAT cycles after accept
        for (int i = 0; i < 6; i++)
            issue(1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'(11'h18 + i), 32'hDEAD_BEEF, 1'b0, 1);
        drain();

        // stall: accept drops after 4, then 4 back-to-back acks on release
        base = ack_log.size();
        @(negedge clk_i);
        resp_stall_i = 1'b1;
        fork
            for (int i = 0; i < 6; i++)
                issue(1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'(11'h20 + i),
                      32'hDEAD_BEEF, 1'b0, 0);
            begin
                repeat (12) @(negedge clk_i);
                check("stall_accept_low", 32'(bus.mem_d_accept_o), 32'd0);
                check("stall_no_ack", 32'(ack_log.size() - base), 32'd0);
                rel_cyc = cyc;
                resp_stall_i = 1'b0;
            end
        join
        drain();
        check("stall_ack_total", 32'(ack_log.size() - base), 32'd6);
        if (ack_log.size() - base >= 4) begin
            check("stall_first_ack", 32'(ack_log[base]), 32'(rel_cyc + 1));
            for (int i = 0; i < 3; i++)
                check("stall_consecutive", 32'(ack_log[base+i+1]), 32'(ack_log[base+i] + 1));
        end

        // reset with 3 reads outstanding
        @(negedge clk_i);
        resp_stall_i = 1'b1;
        for (int i = 0; i < 3; i++)
            issue(1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'(11'h30 + i), 32'hDEAD_BEEF, 1'b0, 0);
        @(negedge clk_i);
        #2 rst_i = 1'b0;
        exp_q.delete();
        base = ack_log.size();
        resp_stall_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("post_rst_accept", 32'(bus.mem_d_accept_o), 32'd1);
        check("post_rst_count", 32'(dut.cnt_q), 32'd0);
        repeat (10) @(negedge clk_i);
        check("post_rst_no_ack", 32'(ack_log.size() - base), 32'd0);
        issue(1, 4'h0, 3'b000, 32'h8000_0004, 32'h0, 11'h40, 32'hDEAD_BEEF, 1'b0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
